// File: rtl/sync_fifo_ram.sv
// Synchronous FIFO built on a simple dual-port RAM with a registered read,
// followed by a first-word-fall-through output register. The RAM read
// register acts as the single in-flight stage between storage and output.
module sync_fifo_ram #(
    parameter int DATA_WIDTH        = 64,
    parameter int ADDR_WIDTH        = 6,
    parameter int ALMOST_FULL_LEVEL = 60
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [DATA_WIDTH-1:0] enq_data,
    output logic                  deq_valid,
    input  logic                  deq_ready,
    output logic [DATA_WIDTH-1:0] deq_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_W   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AF_W    = ALMOST_FULL_LEVEL[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  inflight;   // ram_q holds a word not yet moved to the output
    logic [ADDR_WIDTH:0]   ram_cnt;    // words still sitting unread in the RAM
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  wr_en, deq_fire, load, rd_issue;

    // Ready depends on registered occupancy only, never on the consumer.
    assign enq_ready = (count < DEPTH_W);
    assign wr_en     = enq_valid & enq_ready & ~flush;
    assign deq_fire  = deq_valid & deq_ready & ~flush;
    // The in-flight word moves out when the output register is empty or being taken.
    assign load      = inflight & (~deq_valid | deq_ready) & ~flush;
    assign ram_cnt   = count - {{ADDR_WIDTH{1'b0}}, inflight} - {{ADDR_WIDTH{1'b0}}, deq_valid};
    // Read whenever the read register is free or being emptied this edge.
    assign rd_issue  = (ram_cnt != '0) & (~inflight | load) & ~flush;

    // Next occupancy: flush empties, otherwise +1/-1 per single-sided transfer.
    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (wr_en & ~deq_fire)
            count_nxt = count + ONE_W;
        else if (deq_fire & ~wr_en)
            count_nxt = count - ONE_W;
    end

    // RAM write port; contents are never reset.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= enq_data;
    end

    // RAM registered read port; holds its value until the next read.
    always_ff @(posedge clock) begin
        if (rd_issue)
            ram_q <= mem[rd_ptr];
    end

    // Pointers, occupancy, in-flight flag and output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            deq_valid   <= 1'b0;
            deq_data    <= '0;
            almost_full <= 1'b0;
        end else begin
            count       <= count_nxt;
            almost_full <= (count_nxt >= AF_W);
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                inflight  <= 1'b0;
                deq_valid <= 1'b0;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                if (rd_issue)
                    rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                if (rd_issue)
                    inflight <= 1'b1;
                else if (load)
                    inflight <= 1'b0;
                if (load) begin
                    deq_valid <= 1'b1;
                    deq_data  <= ram_q;
                end else if (deq_fire) begin
                    deq_valid <= 1'b0;
                end
            end
        end
    end

endmodule
